// File: rtl/axi_mem_responder_128bit.sv
// axi_mem_responder_128bit
// AXI4 slave memory model for the 128-bit test master port. Holds a
// word-addressed array and runs independent write and read channel FSMs.
// Every burst is treated as INCR and wraps modulo the array depth.
// The array has no reset, so its contents survive rst_n.
// Optional feature macro: AXI_RESP_BACKPRESSURE_EN. When it is defined, a
// 16-bit LFSR pseudo-randomly pulls awready/wready/arready low.
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready high, waiting for an address
//   W_DATA | wready high, counting beats up to awlen
//   W_RESP | bvalid high, waiting for bready
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for an address
//   R_DATA | rvalid high, presenting beats until the rlast handshake
module axi_mem_responder_128bit #(
  parameter int MEM_AW     = 10,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [7:0]            axi_awid,
  input  logic [7:0]            axi_awlen,
  input  logic [2:0]            axi_awsize,
  input  logic [1:0]            axi_awburst,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [127:0]          axi_wdata,
  input  logic [15:0]           axi_wstrb,
  input  logic                  axi_wlast,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  output logic [7:0]            axi_bid,
  output logic [1:0]            axi_bresp,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic [7:0]            axi_arid,
  input  logic [7:0]            axi_arlen,
  input  logic [2:0]            axi_arsize,
  input  logic [1:0]            axi_arburst,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  output logic [127:0]          axi_rdata,
  output logic [7:0]            axi_rid,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rlast,
  output logic                  axi_rvalid,
  input  logic                  axi_rready
);

  localparam int                DEPTH   = 1 << MEM_AW;
  localparam logic [MEM_AW-1:0] IDX_ONE = MEM_AW'(1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic [127:0] mem [DEPTH];

  logic [MEM_AW-1:0] wr_idx, rd_idx, rd_idx_nxt, aw_idx, ar_idx;
  logic [7:0]        wr_len, wr_cnt, rd_len, rd_cnt;
  logic              wr_size_err, wr_last_err, rd_size_err, ar_size_err;
  logic              aw_fire, w_fire, b_fire, ar_fire, r_fire, w_final;
  logic              aw_gate, w_gate, ar_gate;
  logic              unused_sigs;

  assign aw_fire     = axi_awvalid & axi_awready;
  assign w_fire      = axi_wvalid & axi_wready;
  assign b_fire      = axi_bvalid & axi_bready;
  assign ar_fire     = axi_arvalid & axi_arready;
  assign r_fire      = axi_rvalid & axi_rready;
  assign w_final     = (wr_cnt == wr_len);
  assign aw_idx      = axi_awaddr[MEM_AW+3:4];
  assign ar_idx      = axi_araddr[MEM_AW+3:4];
  assign rd_idx_nxt  = rd_idx + IDX_ONE;
  assign ar_size_err = (axi_arsize != 3'd4);

  // Burst type, byte offset and address bits above the array are don't-care.
  assign unused_sigs = ^{axi_awburst, axi_arburst,
                         axi_awaddr[3:0], axi_awaddr[ADDR_WIDTH-1:MEM_AW+4],
                         axi_araddr[3:0], axi_araddr[ADDR_WIDTH-1:MEM_AW+4]};

`ifdef AXI_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr, lfsr_nxt;

  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Free-running backpressure LFSR.
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= lfsr_nxt;
  end

  // Readies are registered, so they are gated with the value the LFSR holds
  // during the cycle in which they are visible.
  assign aw_gate = (lfsr_nxt[1:0] != 2'b00);
  assign w_gate  = (lfsr_nxt[3:2] != 2'b00);
  assign ar_gate = (lfsr_nxt[5:4] != 2'b00);
`else
  assign aw_gate = 1'b1;
  assign w_gate  = 1'b1;
  assign ar_gate = 1'b1;
`endif

  // Write channel next-state.
  always_comb begin
    wr_state_nxt = wr_state;
    unique case (wr_state)
      W_IDLE:  if (aw_fire) wr_state_nxt = W_DATA;
      W_DATA:  if (w_fire && w_final) wr_state_nxt = W_RESP;
      W_RESP:  if (b_fire) wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // Write state register; readies follow the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state    <= W_IDLE;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
    end else begin
      wr_state    <= wr_state_nxt;
      axi_awready <= (wr_state_nxt == W_IDLE) & aw_gate;
      axi_wready  <= (wr_state_nxt == W_DATA) & w_gate;
    end
  end

  // Write burst bookkeeping and B response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx      <= '0;
      wr_len      <= 8'd0;
      wr_cnt      <= 8'd0;
      wr_size_err <= 1'b0;
      wr_last_err <= 1'b0;
      axi_bid     <= 8'd0;
      axi_bresp   <= 2'b00;
      axi_bvalid  <= 1'b0;
    end else begin
      if (aw_fire) begin
        wr_idx      <= aw_idx;
        wr_len      <= axi_awlen;
        wr_cnt      <= 8'd0;
        wr_size_err <= (axi_awsize != 3'd4);
        wr_last_err <= 1'b0;
        axi_bid     <= axi_awid;
      end
      if (w_fire) begin
        wr_idx <= wr_idx + IDX_ONE;
        wr_cnt <= wr_cnt + 8'd1;
        if (axi_wlast != w_final) wr_last_err <= 1'b1;
        if (w_final) begin
          axi_bvalid <= 1'b1;
          axi_bresp  <= (wr_size_err | wr_last_err | (axi_wlast != w_final)) ? 2'b10 : 2'b00;
        end
      end
      if (b_fire) axi_bvalid <= 1'b0;
    end
  end

  // Byte-enabled array write; a bad awsize consumes beats without writing.
  always_ff @(posedge clk) begin
    if (rst_n && w_fire && !wr_size_err) begin
      for (int i = 0; i < 16; i++) begin
        if (axi_wstrb[i]) mem[wr_idx][8*i +: 8] <= axi_wdata[8*i +: 8];
      end
    end
  end

  // Read channel next-state.
  always_comb begin
    rd_state_nxt = rd_state;
    unique case (rd_state)
      R_IDLE:  if (ar_fire) rd_state_nxt = R_DATA;
      R_DATA:  if (r_fire && axi_rlast) rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Read state register; arready follows the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state    <= R_IDLE;
      axi_arready <= 1'b0;
    end else begin
      rd_state    <= rd_state_nxt;
      axi_arready <= (rd_state_nxt == R_IDLE) & ar_gate;
    end
  end

  // Read beat generation; the next beat is loaded on each handshake so
  // back-to-back transfers need no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_idx      <= '0;
      rd_len      <= 8'd0;
      rd_cnt      <= 8'd0;
      rd_size_err <= 1'b0;
      axi_rid     <= 8'd0;
      axi_rdata   <= 128'd0;
      axi_rresp   <= 2'b00;
      axi_rlast   <= 1'b0;
      axi_rvalid  <= 1'b0;
    end else if (ar_fire) begin
      rd_idx      <= ar_idx;
      rd_len      <= axi_arlen;
      rd_cnt      <= 8'd0;
      rd_size_err <= ar_size_err;
      axi_rid     <= axi_arid;
      axi_rvalid  <= 1'b1;
      axi_rlast   <= (axi_arlen == 8'd0);
      axi_rresp   <= ar_size_err ? 2'b10 : 2'b00;
      axi_rdata   <= ar_size_err ? 128'd0 : mem[ar_idx];
    end else if (r_fire) begin
      if (axi_rlast) begin
        axi_rvalid <= 1'b0;
        axi_rlast  <= 1'b0;
      end else begin
        rd_idx    <= rd_idx_nxt;
        rd_cnt    <= rd_cnt + 8'd1;
        axi_rlast <= ((rd_cnt + 8'd1) == rd_len);
        axi_rdata <= rd_size_err ? 128'd0 : mem[rd_idx_nxt];
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_responder_128bit.sv
// Testbench for axi_mem_responder_128bit: randomized and directed bursts,
// scoreboard queues filled at issue time from a word-array reference model,
// drained by a monitor that watches B and R handshakes.
module tb_axi_mem_responder_128bit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  awaddr, araddr;
  logic [7:0]   awid, awlen, arid, arlen;
  logic [2:0]   awsize, arsize;
  logic [1:0]   awburst, arburst;
  logic         awvalid, awready, wlast, wvalid, wready;
  logic [127:0] wdata, rdata;
  logic [15:0]  wstrb;
  logic [7:0]   bid, rid;
  logic [1:0]   bresp, rresp;
  logic         bvalid, bready, arvalid, arready, rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_mem_responder_128bit #(.MEM_AW(10), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_awaddr(awaddr), .axi_awid(awid), .axi_awlen(awlen), .axi_awsize(awsize),
    .axi_awburst(awburst), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid),
    .axi_wready(wready),
    .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arid(arid), .axi_arlen(arlen), .axi_arsize(arsize),
    .axi_arburst(arburst), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rid(rid), .axi_rresp(rresp), .axi_rlast(rlast),
    .axi_rvalid(rvalid), .axi_rready(rready)
  );

  typedef struct {logic [7:0] id; logic [1:0] resp;} b_t;
  typedef struct {logic [127:0] data; logic [7:0] id; logic [1:0] resp; logic last;} r_t;

  logic [127:0] model [1024];
  b_t bq[$];
  r_t rq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL timeout_%s: got no handshake, expected one within bound", name);
  endtask

  // Monitor: scoreboard pops on B/R handshakes, plus R stability under stall.
  logic         stall_prev = 1'b0;
  logic [139:0] r_saved;
  initial begin : monitor
    b_t be;
    r_t re;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bvalid && bready) begin
        if (bq.size() == 0) tmo("b_unexpected");
        else begin
          be = bq.pop_front();
          chk("bid", bid, be.id);
          chk("bresp", bresp, be.resp);
        end
      end
      if (rst_n === 1'b1 && rvalid && rready) begin
        if (rq.size() == 0) tmo("r_unexpected");
        else begin
          re = rq.pop_front();
          chk("rdata", rdata, re.data);
          chk("rid", rid, re.id);
          chk("rresp", rresp, re.resp);
          chk("rlast", rlast, re.last);
        end
      end
      if (rst_n === 1'b1 && stall_prev) begin
        checks++;
        if ({rvalid, rdata, rid, rresp, rlast} !== r_saved) begin
          errors++;
          $display("FAIL r_stable: got %h expected %h", {rvalid, rdata, rid, rresp, rlast}, r_saved);
        end
      end
      stall_prev = (rst_n === 1'b1) && rvalid && !rready;
      r_saved    = {rvalid, rdata, rid, rresp, rlast};
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [127:0] d[$], input logic [15:0] s[$],
                          input int bad_last);
    b_t e;
    int n, w;
    e.id   = id;
    e.resp = (size != 3'd4 || (bad_last >= 0 && bad_last != int'(len))) ? 2'b10 : 2'b00;
    bq.push_back(e);
    if (size == 3'd4) begin
      for (int i = 0; i <= int'(len); i++) begin
        w = (int'(addr[13:4]) + i) % 1024;
        for (int b = 0; b < 16; b++)
          if (s[i][b]) model[w][8*b +: 8] = d[i][8*b +: 8];
      end
    end
    awaddr = addr; awid = id; awlen = len; awsize = size; awburst = 2'b01; awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 500) begin @(negedge clk); n++; end
    if (!awready) begin tmo("aw"); awvalid = 1'b0; return; end
    @(posedge clk); #1;
    awvalid = 1'b0;
`ifndef AXI_RESP_BACKPRESSURE_EN
    chk("wready_after_aw", wready, 1);
`endif
    for (int i = 0; i <= int'(len); i++) begin
      wdata = d[i]; wstrb = s[i];
      wlast = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
      wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!wready && n < 500) begin @(negedge clk); n++; end
      if (!wready) begin tmo("w"); wvalid = 1'b0; return; end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_after_last", bvalid, 1);
    n = $urandom_range(0, 2);
    repeat (n) begin @(posedge clk); #1; end
    chk("bvalid_held", bvalid, 1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bvalid_drop", bvalid, 0);
`ifndef AXI_RESP_BACKPRESSURE_EN
    chk("awready_after_b", awready, 1);
`endif
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len,
                         input logic [2:0] size, input int mode);
    r_t e;
    int n, got, w;
    for (int i = 0; i <= int'(len); i++) begin
      w      = (int'(addr[13:4]) + i) % 1024;
      e.data = (size == 3'd4) ? model[w] : 128'd0;
      e.id   = id;
      e.resp = (size == 3'd4) ? 2'b00 : 2'b10;
      e.last = (i == int'(len));
      rq.push_back(e);
    end
    araddr = addr; arid = id; arlen = len; arsize = size; arburst = 2'b01; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 500) begin @(negedge clk); n++; end
    if (!arready) begin tmo("ar"); arvalid = 1'b0; return; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid_after_ar", rvalid, 1);
    got = 0; n = 0;
    while (got <= int'(len) && n < 2000) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = 1'($urandom_range(0, 1));
        default: rready = (n % 2 == 0);
      endcase
      @(negedge clk);
      if (rvalid && rready) got++;
      @(posedge clk); #1;
      n++;
    end
    rready = 1'b0;
    if (got <= int'(len)) begin tmo("r_beats"); return; end
    chk("rvalid_after_rlast", rvalid, 0);
`ifndef AXI_RESP_BACKPRESSURE_EN
    chk("arready_after_rlast", arready, 1);
`endif
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [127:0] dq[$];
    logic [15:0]  sq[$];
    int h, ww, wl, rw, rl, md;
    logic [2:0] ws, rs;
    logic [31:0] wa;

    rst_n = 1'b0;
    awaddr = 0; awid = 0; awlen = 0; awsize = 3'd4; awburst = 2'b01;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    araddr = 0; arid = 0; arlen = 0; arsize = 3'd4; arburst = 2'b01; rready = 0;
    awvalid = 1'b1; arvalid = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {awready, wready, bvalid, bresp, bid, arready, rvalid, rid, rresp, rlast}, 0);
    chk("reset_rdata", rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; awvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1;
`ifndef AXI_RESP_BACKPRESSURE_EN
    chk("awready_after_reset", awready, 1);
    chk("arready_after_reset", arready, 1);
`endif

    // Prefill the whole array so every later read has a defined model value.
    for (int k = 0; k < 4; k++) begin
      dq.delete(); sq.delete();
      for (int i = 0; i < 256; i++) begin
        dq.push_back({$urandom, $urandom, $urandom, $urandom});
        sq.push_back(16'hFFFF);
      end
      do_write(32'(k * 4096), 8'(k), 8'd255, 3'd4, dq, sq, -1);
    end

    // Basic 4-beat burst at 0x40 and read back.
    dq.delete(); sq.delete();
    for (int i = 1; i <= 4; i++) begin dq.push_back(128'(i)); sq.push_back(16'hFFFF); end
    do_write(32'h40, 8'h5A, 8'd3, 3'd4, dq, sq, -1);
    do_read(32'h40, 8'h33, 8'd3, 3'd4, 0);
    chk("model_word4", model[4], 128'h1);

    // Partial strobe on word 5.
    dq.delete(); sq.delete();
    dq.push_back({128{1'b1}}); sq.push_back(16'hFFFF);
    do_write(32'h50, 8'h01, 8'd0, 3'd4, dq, sq, -1);
    dq.delete(); sq.delete();
    dq.push_back(128'd0); sq.push_back(16'h0001);
    do_write(32'h50, 8'h02, 8'd0, 3'd4, dq, sq, -1);
    do_read(32'h50, 8'h03, 8'd0, 3'd4, 0);

    // Wrap from word 1023 to word 0.
    dq.delete(); sq.delete();
    dq.push_back(128'hA); dq.push_back(128'hB); sq.push_back(16'hFFFF); sq.push_back(16'hFFFF);
    do_write(32'h3FF0, 8'h44, 8'd1, 3'd4, dq, sq, -1);
    do_read(32'h3FF0, 8'h45, 8'd1, 3'd4, 0);
    do_read(32'h0, 8'h46, 8'd0, 3'd4, 1);

    // Errors: bad awsize leaves the array alone; early wlast; bad arsize.
    dq.delete(); sq.delete();
    for (int i = 0; i < 4; i++) begin dq.push_back(128'hDEAD); sq.push_back(16'hFFFF); end
    do_write(32'h40, 8'h70, 8'd3, 3'd3, dq, sq, -1);
    do_read(32'h40, 8'h71, 8'd3, 3'd4, 0);
    dq.delete(); sq.delete();
    for (int i = 0; i < 3; i++) begin dq.push_back(128'(100 + i)); sq.push_back(16'hFFFF); end
    do_write(32'h100, 8'h72, 8'd2, 3'd4, dq, sq, 1);
    do_read(32'h100, 8'h73, 8'd2, 3'd4, 0);
    do_read(32'h40, 8'h74, 8'd1, 3'd2, 0);

    // Overlapping write and read with rready toggling 1-0-1.
    dq.delete(); sq.delete();
    for (int i = 0; i < 8; i++) begin dq.push_back({$urandom, $urandom, $urandom, $urandom}); sq.push_back(16'hFFFF); end
    fork
      do_write(32'h2580, 8'h80, 8'd7, 3'd4, dq, sq, -1);
      do_read(32'h40, 8'h81, 8'd3, 3'd4, 2);
    join

    // Random overlapping bursts in opposite halves of the array.
    for (int it = 0; it < 30; it++) begin
      h  = $urandom_range(0, 1);
      ww = h * 512 + $urandom_range(0, 496);
      wl = $urandom_range(0, 15);
      rw = (1 - h) * 512 + $urandom_range(0, 496);
      rl = $urandom_range(0, 15);
      md = $urandom_range(0, 2);
      ws = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'd4;
      rs = ($urandom_range(0, 7) == 0) ? 3'd2 : 3'd4;
      wa = 32'(ww * 16 + $urandom_range(0, 15)) | (32'($urandom_range(0, 3)) << 14);
      dq.delete(); sq.delete();
      for (int i = 0; i <= wl; i++) begin
        dq.push_back({$urandom, $urandom, $urandom, $urandom});
        sq.push_back(16'($urandom_range(0, 65535)));
      end
      fork
        do_write(wa, 8'(it), 8'(wl), ws, dq, sq, -1);
        do_read(32'(rw * 16), 8'(it + 100), 8'(rl), rs, md);
      join
    end

    repeat (4) @(posedge clk);
    #1;
    chk("b_queue_empty", 128'(bq.size()), 0);
    chk("r_queue_empty", 128'(rq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
